// File: rtl/lockout_timer.sv
// lockout_timer: counts consecutive wrong-password results and enforces a timed lockout
// Ports: clk/system_reset_n (async, active-low); correct_password, incorrect_password,
//   sleep are levels whose rising edges are events; lockout is high during a lockout,
//   end_sleep pulses one cycle when it ends; fail_count is the consecutive-failure
//   count; lock_level is the escalation level.
// Optional: define LOCKOUT_ESCALATE_EN to double the lockout length on each
//   successive lockout (1x, 2x, 4x, 4x ...); otherwise lock_level is tied to 0.
module lockout_timer #(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 250000000,
  parameter int CNT_W       = 30
) (
  input  logic       clk,
  input  logic       system_reset_n,
  input  logic       correct_password,
  input  logic       incorrect_password,
  input  logic       sleep,
  output logic       lockout,
  output logic       end_sleep,
  output logic [3:0] fail_count,
  output logic [1:0] lock_level
);
  typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} state_t;
  localparam logic [3:0]       MAX_FC = 4'(MAX_FAILS);
  localparam logic [CNT_W-1:0] BASE   = CNT_W'(LOCK_CYCLES);
  state_t           state_q, state_d;
  logic             corr_q, inc_q, slp_q;
  logic             corr_ev, inc_ev, slp_ev, enter;
  logic [3:0]       fail_count_q, fail_count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lockout_q, lockout_d, end_sleep_q, end_sleep_d;
  logic [1:0]       lvl_q;
  assign corr_ev = correct_password & ~corr_q;
  assign inc_ev  = incorrect_password & ~inc_q;
  assign slp_ev  = sleep & ~slp_q;
  always_comb begin
    state_d      = state_q;
    fail_count_d = fail_count_q;
    cnt_d        = cnt_q;
    enter        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slp_ev) enter = 1'b1;
        else if (corr_ev) fail_count_d = 4'd0;
        else if (inc_ev) begin
          fail_count_d = fail_count_q + 4'd1;
          enter        = (fail_count_q + 4'd1) == MAX_FC;
        end
      end
      LOCKED: begin
        if (cnt_q == '0) begin
          state_d      = RELEASE;
          fail_count_d = 4'd0;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      RELEASE: begin
        state_d      = IDLE;
        fail_count_d = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    // load uses the level in force before this entry's escalation
    if (enter) begin
      state_d = LOCKED;
      cnt_d   = (BASE << lvl_q) - CNT_W'(1);
    end
    lockout_d   = state_d == LOCKED;
    end_sleep_d = state_d == RELEASE;
  end
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= IDLE;
      corr_q       <= 1'b0;
      inc_q        <= 1'b0;
      slp_q        <= 1'b0;
      fail_count_q <= 4'd0;
      cnt_q        <= '0;
      lockout_q    <= 1'b0;
      end_sleep_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      corr_q       <= correct_password;
      inc_q        <= incorrect_password;
      slp_q        <= sleep;
      fail_count_q <= fail_count_d;
      cnt_q        <= cnt_d;
      lockout_q    <= lockout_d;
      end_sleep_q  <= end_sleep_d;
    end
  end
`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] lvl_d;
  always_comb begin
    lvl_d = lvl_q;
    if (state_q == IDLE && !slp_ev && corr_ev) lvl_d = 2'd0;
    else if (enter && lvl_q != 2'd2) lvl_d = lvl_q + 2'd1;
  end
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) lvl_q <= 2'd0;
    else lvl_q <= lvl_d;
  end
`else
  assign lvl_q = 2'd0;
`endif
  assign lockout    = lockout_q;
  assign end_sleep  = end_sleep_q;
  assign fail_count = fail_count_q;
  assign lock_level = lvl_q;
endmodule
